// File: rtl/simple_exec_stage_pkg.sv
// Shared definitions for the simple core execute stage.
//   exec_op_e    : 4-bit opcode carried on op_i of simple_exec_stage
//   exec_state_e : execute-stage control states (IDLE, MUL_BUSY)
//   MUL_CYCLES   : iterations of the shift-add multiplier
//   MUL_CNT_W    : width of the multiplier iteration counter
package simple_definitions;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    SLL = 4'd5,
    SRL = 4'd6,
    SRA = 4'd7,
    SLT = 4'd8,
    MOV = 4'd9,
    MUL = 4'd10
  } exec_op_e;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } exec_state_e;

  localparam int unsigned MUL_CYCLES = 32;
  localparam int unsigned MUL_CNT_W  = $clog2(MUL_CYCLES);

endpackage

// File: rtl/simple_exec_stage_iter_mul.sv
// Iterative 32x32->32 shift-add multiplier (low half of the product).
// Compiled only when SIMPLE_EXEC_MUL_EN is defined.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start_i          : load operands and begin (ignored while busy)
//   multiplicand_i   : value shifted left each iteration
//   multiplier_i     : value shifted right each iteration; bit 0 gates the add
//   busy_o           : iterating
//   done_o           : one-cycle pulse after the final iteration
//   product_o        : accumulator; final product valid while done_o=1
`ifdef SIMPLE_EXEC_MUL_EN
module simple_iter_mul
  import simple_definitions::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] multiplicand_i,
  input  logic [31:0] multiplier_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o
);

  logic [31:0]          mcand_q,  mcand_d;
  logic [31:0]          mplier_q, mplier_d;
  logic [31:0]          acc_q,    acc_d;
  logic [MUL_CNT_W-1:0] cnt_q,    cnt_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == MUL_CNT_W'(MUL_CYCLES - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start_i) begin
      mcand_d  = multiplicand_i;
      mplier_d = multiplier_i;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule
`endif

// File: rtl/simple_exec_stage.sv
// Execute stage downstream of the simple core register file.
// Computes result = rd OP rs and presents a registered writeback request.
// Single-cycle ALU ops have latency 1; MUL (when SIMPLE_EXEC_MUL_EN is
// defined) runs on simple_iter_mul and presents its result 33 cycles after
// accept. Without SIMPLE_EXEC_MUL_EN, MUL is reported as an illegal opcode.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   valid_i / ready_o     : upstream handshake (ready_o combinational)
//   op_i                  : opcode (simple_definitions::exec_op_e)
//   rs_val_i, rd_val_i    : operands from the register file
//   rd_addr_i             : writeback register address
//   valid_o / ready_i     : downstream writeback handshake
//   result_o, wr_addr_o   : writeback value and address
//   illegal_o             : unsupported opcode, qualified by valid_o
module simple_exec_stage
  import simple_definitions::*;
#(
  parameter int unsigned addr_width_p = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [3:0]              op_i,
  input  logic [31:0]             rs_val_i,
  input  logic [31:0]             rd_val_i,
  input  logic [addr_width_p-1:0] rd_addr_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [31:0]             result_o,
  output logic [addr_width_p-1:0] wr_addr_o,
  output logic                    illegal_o
);

  exec_op_e op;
  logic [4:0]  sh;
  logic [31:0] alu_res;
  logic        alu_ill;
  logic        accept;
  logic        out_free;

  logic                    valid_q,   valid_d;
  logic [31:0]             result_q,  result_d;
  logic [addr_width_p-1:0] wr_addr_q, wr_addr_d;
  logic                    illegal_q, illegal_d;

  assign op       = exec_op_e'(op_i);
  assign sh       = rs_val_i[4:0];
  assign out_free = !valid_q || ready_i;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op)
      ADD:     alu_res = rd_val_i + rs_val_i;
      SUB:     alu_res = rd_val_i - rs_val_i;
      AND:     alu_res = rd_val_i & rs_val_i;
      OR:      alu_res = rd_val_i | rs_val_i;
      XOR:     alu_res = rd_val_i ^ rs_val_i;
      SLL:     alu_res = rd_val_i << sh;
      SRL:     alu_res = rd_val_i >> sh;
      SRA:     alu_res = 32'($signed(rd_val_i) >>> sh);
      SLT:     alu_res = {31'b0, $signed(rd_val_i) < $signed(rs_val_i)};
      MOV:     alu_res = rs_val_i;
`ifdef SIMPLE_EXEC_MUL_EN
      // Result arrives later from the multiplier; the ALU path is unused.
      MUL:     alu_res = '0;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef SIMPLE_EXEC_MUL_EN
  exec_state_e state_q, state_d;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [31:0] mul_product;

  assign ready_o = !reset && (state_q == IDLE) && out_free;
  assign accept  = valid_i && ready_o;

  simple_iter_mul u_mul (
    .clk            (clk),
    .reset          (reset),
    .start_i        (mul_start),
    .multiplicand_i (rd_val_i),
    .multiplier_i   (rs_val_i),
    .busy_o         (mul_busy),
    .done_o         (mul_done),
    .product_o      (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    result_d  = result_q;
    wr_addr_d = wr_addr_q;
    illegal_d = illegal_q;
    mul_start = 1'b0;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_addr_d = rd_addr_i;
          if (op == MUL) begin
            // Output slot is already free (accept requires it), so valid_d
            // has been cleared above if the old result was consumed.
            mul_start = 1'b1;
            state_d   = MUL_BUSY;
          end else begin
            result_d  = alu_res;
            illegal_d = alu_ill;
            valid_d   = 1'b1;
          end
        end
      end
      MUL_BUSY: begin
        if (mul_done) begin
          result_d  = mul_product;
          illegal_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = IDLE;
        end else if (!mul_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign ready_o = !reset && out_free;
  assign accept  = valid_i && ready_o;

  always_comb begin
    valid_d   = valid_q;
    result_d  = result_q;
    wr_addr_d = wr_addr_q;
    illegal_d = illegal_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      wr_addr_d = rd_addr_i;
      result_d  = alu_res;
      illegal_d = alu_ill;
      valid_d   = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      wr_addr_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      wr_addr_q <= wr_addr_d;
      illegal_q <= illegal_d;
    end
  end

  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign wr_addr_o = wr_addr_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_simple_exec_stage.sv
module tb_simple_exec_stage;
  import simple_definitions::*;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_i;
  logic          ready_o;
  logic [3:0]    op_i;
  logic [31:0]   rs_val_i;
  logic [31:0]   rd_val_i;
  logic [AW-1:0] rd_addr_i;
  logic          valid_o;
  logic          ready_i;
  logic [31:0]   result_o;
  logic [AW-1:0] wr_addr_o;
  logic          illegal_o;

  always #5 clk = ~clk;

  simple_exec_stage #(.addr_width_p(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .op_i      (op_i),
    .rs_val_i  (rs_val_i),
    .rd_val_i  (rd_val_i),
    .rd_addr_i (rd_addr_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result_o  (result_o),
    .wr_addr_o (wr_addr_o),
    .illegal_o (illegal_o)
  );

  typedef struct {
    logic [31:0]   res;
    logic [AW-1:0] addr;
    logic          ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: every writeback transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && valid_o === 1'b1 && ready_i === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wb actual=0x%08h required=none", result_o);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_result",  result_o,         mon_e.res);
        chk("wb_addr",    32'(wr_addr_o),   32'(mon_e.addr));
        chk("wb_illegal", 32'(illegal_o),   32'(mon_e.ill));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called and returns at posedge+1; pushes the expectation once accepted.
  task automatic send(input logic [3:0] op, input logic [31:0] rd, input logic [31:0] rs,
                      input logic [AW-1:0] a, input logic [31:0] er, input logic ei,
                      input bit push);
    int n;
    exp_t e;
    valid_i   = 1'b1;
    op_i      = op;
    rd_val_i  = rd;
    rs_val_i  = rs;
    rd_addr_i = a;
    n = 0;
    @(negedge clk);
    while (ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=%0d required=<200", n);
    end else if (push) begin
      e.res  = er;
      e.addr = a;
      e.ill  = ei;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  logic [3:0]  v_op [9] = '{SUB, AND, OR, XOR, SLL, SRL, SLT, SLT, MOV};
  logic [31:0] v_rd [9] = '{32'd10, 32'hF0F0_F0F0, 32'hF000_0000, 32'hAAAA_AAAA, 32'h1,
                            32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h123};
  logic [31:0] v_rs [9] = '{32'd3, 32'h0FF0_0FF0, 32'h0000_000F, 32'hFFFF_FFFF, 32'h21,
                            32'h1F, 32'h1, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
  logic [31:0] v_ex [9] = '{32'd7, 32'h00F0_00F0, 32'hF000_000F, 32'h5555_5555, 32'h2,
                            32'h1, 32'h1, 32'h0, 32'hDEAD_BEEF};

  initial begin
    int n;
    int cnt;
    reset     = 1'b1;
    valid_i   = 1'b1;
    op_i      = ADD;
    rd_val_i  = 32'h1;
    rs_val_i  = 32'h1;
    rd_addr_i = '0;
    ready_i   = 1'b1;

    repeat (2) begin
      @(negedge clk);
      chk("reset_ready_o", 32'(ready_o),  32'd0);
      chk("reset_valid_o", 32'(valid_o),  32'd0);
      chk("reset_result",  result_o,      32'd0);
    end
    @(posedge clk);
    #1;
    reset   = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1;

    send(ADD, 32'hFFFF_FFFF, 32'h1, 4'd3, 32'h0, 1'b0, 1'b1);
    chk("add_latency_valid", 32'(valid_o), 32'd1);
    send(SRA, 32'h8000_0000, 32'h24, 4'd5, 32'hF800_0000, 1'b0, 1'b1);

    for (int i = 0; i < 9; i++) begin
      send(v_op[i], v_rd[i], v_rs[i], AW'(i), v_ex[i], 1'b0, 1'b1);
    end

    // Backpressure hold, then consume and accept in the same edge.
    idle(1);
    ready_i = 1'b0;
    send(SUB, 32'd5, 32'd7, 4'd7, 32'hFFFF_FFFE, 1'b0, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("bp_valid_o", 32'(valid_o), 32'd1);
      chk("bp_result",  result_o,     32'hFFFF_FFFE);
      chk("bp_ready_o", 32'(ready_o), 32'd0);
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    send(ADD, 32'd2, 32'd2, 4'd8, 32'd4, 1'b0, 1'b1);
    chk("overwrite_valid_o", 32'(valid_o), 32'd1);
    chk("overwrite_result",  result_o,     32'd4);

    send(4'd15, 32'd5, 32'd6, 4'hA, 32'd0, 1'b1, 1'b1);
    chk("illegal_latency_valid", 32'(valid_o), 32'd1);
    idle(1);

`ifdef SIMPLE_EXEC_MUL_EN
    send(MUL, 32'h0001_0001, 32'h0001_0003, 4'd9, 32'h0004_0003, 1'b0, 1'b1);
    n   = 0;
    cnt = 0;
    while (valid_o !== 1'b1 && n < 100) begin
      if (ready_o !== 1'b0) cnt++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_latency",   32'(n),   32'd33);
    chk("mul_ready_low", 32'(cnt), 32'd0);
    idle(1);

    send(MUL, 32'd7, 32'd9, 4'd2, 32'd0, 1'b0, 1'b0);
    idle(9);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_valid_o", 32'(valid_o), 32'd0);
    chk("abort_ready_o", 32'(ready_o), 32'd1);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid_o !== 1'b0) cnt++;
    end
    chk("abort_no_result", 32'(cnt), 32'd0);
    send(ADD, 32'd1, 32'd2, 4'd4, 32'd3, 1'b0, 1'b1);
`else
    send(MUL, 32'h0001_0001, 32'h0001_0003, 4'd9, 32'd0, 1'b1, 1'b1);
    chk("mul_illegal_latency_valid", 32'(valid_o), 32'd1);
`endif

    idle(3);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
